// File: rtl/seq_scan_pkg.sv
// Shared encodings, defaults and detector next-state helper for the seq_scan controller.
package seq_scan_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [1:0] DET_A = 2'b00;
    localparam logic [1:0] DET_B = 2'b01;
    localparam logic [1:0] DET_C = 2'b10;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_CNT_W  = 4;

    // "1-0-0" detector transition; the unused encoding recovers to A.
    function automatic logic [1:0] det_next(input logic [1:0] s, input logic in1);
        logic [1:0] n;
        n = DET_A;
        case (s)
            DET_A:   n = in1 ? DET_B : DET_A;
            DET_B:   n = in1 ? DET_B : DET_C;
            DET_C:   n = in1 ? DET_C : DET_A;
            default: n = DET_A;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/seq_scan_ctrl_det.sv
// seq_det_100: registered Mealy "1-0-0" detector with clock enable and sync reset.
module seq_det_100
    import seq_scan_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    input  logic En,
    input  logic In1,
    output logic Out1
);

    logic [1:0] state_q;
    logic       out1_q;

    // Out1 is a one-cycle pulse tied to an enabled C->A transition.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= DET_A;
            out1_q  <= 1'b0;
        end else if (En) begin
            state_q <= det_next(state_q, In1);
            out1_q  <= (state_q == DET_C) && !In1;
        end else begin
            out1_q  <= 1'b0;
        end
    end

    assign Out1 = out1_q;

endmodule

// File: rtl/seq_scan_ctrl.sv
// Word-to-serial scan controller around seq_det_100 with saturating hit count.
// Define SEQ_SCAN_CONT_EN to keep detector state across words.
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Start,
    input  logic [DATA_W-1:0] DataIn,
    output logic              Busy,
    output logic              Done,
    output logic              Match,
    output logic [CNT_W-1:0]  MatchCnt
);

    localparam int unsigned IDX_W = $clog2(DATA_W);

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              start_acc, det_en, det_in, det_rst, det_out;

    assign start_acc = (state_q == ST_IDLE) && Start;
    assign det_en    = (state_q == ST_SHIFT);
    assign det_in    = det_en ? shreg_q[DATA_W-1] : 1'b0;
    assign Busy      = (state_q == ST_SHIFT) || (state_q == ST_FLUSH);
    assign Done      = (state_q == ST_DONE);
    assign Match     = det_out && Busy;
    assign MatchCnt  = cnt_q;

`ifdef SEQ_SCAN_CONT_EN
    assign det_rst = RST;
`else
    assign det_rst = RST | start_acc;
`endif

    seq_det_100 u_det (
        .CLK  (CLK),
        .RST  (det_rst),
        .En   (det_en),
        .In1  (det_in),
        .Out1 (det_out)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        // The count samples Out1 of the previous bit, so FLUSH is needed for the last one.
        if (Match && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    shreg_d = DataIn;
                    idx_d   = IDX_W'(DATA_W - 1);
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                idx_d   = idx_q - 1'b1;
                if (idx_q == '0) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl: default instance plus a CNT_W=1 instance on shared stimulus.
module tb_seq_scan_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       Start = 1'b0;
    logic [7:0] DataIn = '0;
    logic       Busy, Done, Match;
    logic [3:0] MatchCnt;
    logic       Busy1, Done1, Match1;
    logic [0:0] MatchCnt1;

    int checks = 0;
    int errors = 0;

    // Reference: greedy search for the subsequence 1,0,0 (restart after each hit).
    logic [2:0] pattern = 3'b100;
    int         prog = 0;
    logic       mb [1:8];
    int         nhits;

    seq_scan_ctrl #(.DATA_W(8), .CNT_W(4)) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .DataIn(DataIn),
        .Busy(Busy), .Done(Done), .Match(Match), .MatchCnt(MatchCnt)
    );

    seq_scan_ctrl #(.DATA_W(8), .CNT_W(1)) dut1 (
        .CLK(CLK), .RST(RST), .Start(Start), .DataIn(DataIn),
        .Busy(Busy1), .Done(Done1), .Match(Match1), .MatchCnt(MatchCnt1)
    );

    initial forever #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_word(input logic [7:0] w);
`ifndef SEQ_SCAN_CONT_EN
        prog = 0;
`endif
        nhits = 0;
        for (int k = 1; k <= 8; k++) begin
            logic b;
            b = w[8-k];
            mb[k] = 1'b0;
            if (b == pattern[2-prog]) begin
                prog++;
                if (prog == 3) begin
                    mb[k] = 1'b1;
                    nhits++;
                    prog = 0;
                end
            end
        end
    endtask

    task automatic scan(input logic [7:0] w, input bit hold, input int exp_cnt);
        int ndone;
        int e4, e1;
        ndone = 0;
        model_word(w);
        e4 = (nhits > 15) ? 15 : nhits;
        e1 = (nhits > 1) ? 1 : nhits;
        @(negedge CLK);
        Start = 1'b1;
        DataIn = w;
        for (int s = 0; s <= 10; s++) begin
            @(negedge CLK);
            chk("busy", 32'(Busy), 32'(s <= 8));
            chk("done", 32'(Done), 32'(s == 9));
            chk("match", 32'(Match), (s >= 1 && s <= 8) ? 32'(mb[s]) : 32'd0);
            chk("match_w1", 32'(Match1), (s >= 1 && s <= 8) ? 32'(mb[s]) : 32'd0);
            if (Done) ndone++;
            if (s >= 9) begin
                chk("matchcnt", 32'(MatchCnt), 32'(e4));
                chk("matchcnt_w1", 32'(MatchCnt1), 32'(e1));
                if (exp_cnt >= 0) chk("matchcnt_const", 32'(MatchCnt), 32'(exp_cnt));
            end
            if (hold && s < 10) begin
                Start = 1'b1;
                DataIn = ~w;
            end else begin
                Start = 1'b0;
            end
        end
        chk("done_pulses", 32'(ndone), 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_match", 32'(Match), 32'd0);
        chk("rst_cnt", 32'(MatchCnt), 32'd0);
        RST = 1'b0;
        prog = 0;
        repeat (2) @(negedge CLK);
        chk("idle_busy", 32'(Busy), 32'd0);

        // Directed words; the CNT_W=1 instance covers saturation on 0x90.
        scan(8'h90, 1'b0, 2);
        scan(8'hA4, 1'b0, -1);
        scan(8'hFF, 1'b0, -1);
        scan(8'h00, 1'b0, -1);

        // Start held through a whole scan, DataIn changing mid-scan.
        scan(8'h90, 1'b1, -1);

        // Reset during SHIFT before bit 4 of 0x90.
        @(negedge CLK);
        Start = 1'b1;
        DataIn = 8'h90;
        for (int s = 0; s <= 3; s++) begin
            @(negedge CLK);
            Start = 1'b0;
        end
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        prog = 0;
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_cnt", 32'(MatchCnt), 32'd0);
        chk("abort_match", 32'(Match), 32'd0);
        for (int s = 0; s < 12; s++) begin
            chk("abort_no_done", 32'(Done), 32'd0);
            @(negedge CLK);
        end
        scan(8'h90, 1'b0, 2);

        // Word-boundary behaviour: 0x01 leaves the detector in B.
        prog = 0;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        scan(8'h01, 1'b0, 0);
`ifdef SEQ_SCAN_CONT_EN
        scan(8'h00, 1'b0, 1);
`else
        scan(8'h00, 1'b0, 0);
`endif

        for (int i = 0; i < 16; i++) begin
            scan(8'($urandom), 1'b0, -1);
        end
        scan(8'($urandom), 1'b1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
